// File: rtl/chip8_sound_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chip8_sound_ctrl
// Purpose  : Control stage in front of chip8_audio. It holds the CHIP-8
//            sound timer (ST) and decrements it at TICK_HZ. It also keeps the
//            timbre, tone and volume configuration registers, and drives
//            chip8_audio's active/timbre/tone/vol inputs.
// Ports    : clk_in, rst_in       - clock, synchronous active-high reset
//            pause_in             - freeze divider and timer, mute output
//            st_wr_in/st_data_in  - load ST (FX18)
//            cfg_wr_in/addr/data  - config write (0=timbre,1=tone,2=vol)
//            st_out, tick_out     - ST readback, 1-cycle tick pulse
//            active_out, timbre_out, tone_out, vol_out - to chip8_audio
// Options  : CHIP8_SND_MIN_ST_EN  - discard ST loads of exactly 1
//                                    (COSMAC VIP behaviour)
// Revision : 1.0 - initial release
// ============================================================================
module chip8_sound_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 60,
    parameter int TIMBRE_RST = 2,
    parameter int TONE_RST   = 750,
    parameter int VOL_RST    = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       pause_in,
    input  logic       st_wr_in,
    input  logic [7:0] st_data_in,
    input  logic       cfg_wr_in,
    input  logic [1:0] cfg_addr_in,
    input  logic [9:0] cfg_data_in,
    output logic [7:0] st_out,
    output logic       tick_out,
    output logic       active_out,
    output logic [1:0] timbre_out,
    output logic [9:0] tone_out,
    output logic [2:0] vol_out
);

    localparam int c_DIV   = CLK_HZ / TICK_HZ;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_st;
    logic               r_tick;
    logic               r_active;
    logic [1:0]         r_timbre;
    logic [9:0]         r_tone;
    logic [2:0]         r_vol;

    logic               w_tick;
    logic               w_load;
    logic [7:0]         w_st_next;

    // A tick exists only while the divider is running.
    assign w_tick = (r_cnt == c_CNT_MAX) && !pause_in;

`ifdef CHIP8_SND_MIN_ST_EN
    // The VIP sound routine ignores a single-tick tone, so a load of 1 has no effect.
    assign w_load = st_wr_in && (st_data_in != 8'd1);
`else
    assign w_load = st_wr_in;
`endif

    // A load takes priority over a same-cycle tick, and that tick is lost.
    always_comb begin
        w_st_next = r_st;
        if (w_load) begin
            w_st_next = st_data_in;
        end else if (w_tick && (r_st != 8'd0)) begin
            w_st_next = r_st - 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt    <= '0;
            r_st     <= 8'd0;
            r_tick   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            if (!pause_in) begin
                r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_W'(1);
            end
            r_tick   <= w_tick;
            r_st     <= w_st_next;
            r_active <= (w_st_next != 8'd0) && !pause_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_timbre <= 2'(TIMBRE_RST);
            r_tone   <= 10'(TONE_RST);
            r_vol    <= 3'(VOL_RST);
        end else if (cfg_wr_in) begin
            case (cfg_addr_in)
                2'd0:    r_timbre <= cfg_data_in[1:0];
                2'd1:    r_tone   <= cfg_data_in;
                2'd2:    r_vol    <= cfg_data_in[2:0];
                default: ;
            endcase
        end
    end

    assign st_out     = r_st;
    assign tick_out   = r_tick;
    assign active_out = r_active;
    assign timbre_out = r_timbre;
    assign tone_out   = r_tone;
    assign vol_out    = r_vol;

endmodule
`default_nettype wire

// File: tb/tb_chip8_sound_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip8_sound_ctrl
// Purpose  : Directed self-checking bench for chip8_sound_ctrl with
//            CLK_HZ=600 and TICK_HZ=60, so DIV=10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip8_sound_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_in = 1'b0;
    logic       st_wr_in = 1'b0;
    logic [7:0] st_data_in = 8'd0;
    logic       cfg_wr_in = 1'b0;
    logic [1:0] cfg_addr_in = 2'd0;
    logic [9:0] cfg_data_in = 10'd0;
    logic [7:0] st_out;
    logic       tick_out;
    logic       active_out;
    logic [1:0] timbre_out;
    logic [9:0] tone_out;
    logic [2:0] vol_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chip8_sound_ctrl #(
        .CLK_HZ    (600),
        .TICK_HZ   (60),
        .TIMBRE_RST(2),
        .TONE_RST  (750),
        .VOL_RST   (2)
    ) u_dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .pause_in   (pause_in),
        .st_wr_in   (st_wr_in),
        .st_data_in (st_data_in),
        .cfg_wr_in  (cfg_wr_in),
        .cfg_addr_in(cfg_addr_in),
        .cfg_data_in(cfg_data_in),
        .st_out     (st_out),
        .tick_out   (tick_out),
        .active_out (active_out),
        .timbre_out (timbre_out),
        .tone_out   (tone_out),
        .vol_out    (vol_out)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one edge; inputs and outputs both change/sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until tick_out is seen; returns the number of edges taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_out && n < 40);
        if (!tick_out) check("tick_timeout", 0, 1);
    endtask

    task automatic st_load(input logic [7:0] v);
        st_wr_in   = 1'b1;
        st_data_in = v;
        step();
        st_wr_in   = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [9:0] d);
        cfg_wr_in   = 1'b1;
        cfg_addr_in = a;
        cfg_data_in = d;
        step();
        cfg_wr_in   = 1'b0;
    endtask

    initial begin
        int n;
        int ticks_seen;
        int st_bad;

        // Reset state
        repeat (3) step();
        check("rst_st", st_out, 0);
        check("rst_active", active_out, 0);
        check("rst_tick", tick_out, 0);
        check("rst_timbre", timbre_out, 2);
        check("rst_tone", tone_out, 750);
        check("rst_vol", vol_out, 2);
        rst = 1'b0;

        // The first tick is at edge 10 after release, then every 10 edges.
        wait_tick(n);
        check("first_tick_delay", n, 10);
        wait_tick(n);
        check("tick_period", n, 10);
        step();
        check("tick_one_cycle", tick_out, 0);

        // Load 3 right after a tick; it counts down 3,2,1,0 on successive ticks.
        wait_tick(n);
        st_load(8'd3);
        check("load3_st", st_out, 3);
        check("load3_active", active_out, 1);
        wait_tick(n);
        check("dec_st2", st_out, 2);
        check("dec_active2", active_out, 1);
        wait_tick(n);
        check("dec_st1", st_out, 1);
        check("dec_active1", active_out, 1);
        wait_tick(n);
        check("dec_st0", st_out, 0);
        check("dec_active0", active_out, 0);
        wait_tick(n);
        check("no_wrap", st_out, 0);

        // Load/tick collision: the counter is 0 after a tick, and load 2 moves it to 1.
        st_load(8'd2);
        repeat (8) step();
        check("pre_collide_st", st_out, 2);
        st_load(8'd5);
        check("collide_tick", tick_out, 1);
        check("collide_st", st_out, 5);
        wait_tick(n);
        check("post_collide_st", st_out, 4);

        // Pause with ST=4 and the counter at 0.
        pause_in = 1'b1;
        step();
        check("pause_active", active_out, 0);
        ticks_seen = 0;
        st_bad = 0;
        repeat (50) begin
            step();
            if (tick_out) ticks_seen++;
            if (st_out != 8'd4) st_bad++;
        end
        check("pause_no_tick", ticks_seen, 0);
        check("pause_st_hold", st_bad, 0);
        check("pause_st", st_out, 4);
        pause_in = 1'b0;
        step();
        check("resume_active", active_out, 1);
        wait_tick(n);
        check("resume_count", n, 9);
        check("resume_st", st_out, 3);

        // Config writes
        cfg_write(2'd1, 10'h3FF);
        check("cfg_tone", tone_out, 1023);
        cfg_write(2'd2, 10'h00F);
        check("cfg_vol", vol_out, 7);
        cfg_write(2'd0, 10'h3FD);
        check("cfg_timbre", timbre_out, 1);
        cfg_write(2'd3, 10'h155);
        check("cfg3_timbre", timbre_out, 1);
        check("cfg3_tone", tone_out, 1023);
        check("cfg3_vol", vol_out, 7);

        // A load of 0 mid-tone silences on the next edge.
        check("pre_zero_active", active_out, 1);
        st_load(8'd0);
        check("zero_st", st_out, 0);
        check("zero_active", active_out, 0);

        // Reset mid-tone, with an ST load and a config write in the same cycle.
        st_load(8'd7);
        check("pre_rst_active", active_out, 1);
        rst         = 1'b1;
        st_wr_in    = 1'b1;
        st_data_in  = 8'd9;
        cfg_wr_in   = 1'b1;
        cfg_addr_in = 2'd1;
        cfg_data_in = 10'd5;
        step();
        st_wr_in  = 1'b0;
        cfg_wr_in = 1'b0;
        check("midrst_st", st_out, 0);
        check("midrst_active", active_out, 0);
        check("midrst_timbre", timbre_out, 2);
        check("midrst_tone", tone_out, 750);
        check("midrst_vol", vol_out, 2);
        rst = 1'b0;

        // A load of 1 while ST=0.
        st_load(8'd1);
`ifdef CHIP8_SND_MIN_ST_EN
        check("min_st", st_out, 0);
        check("min_active", active_out, 0);
`else
        check("min_st", st_out, 1);
        check("min_active", active_out, 1);
`endif
        wait_tick(n);
        check("min_after_st", st_out, 0);
        check("min_after_active", active_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
